// File: rtl/fb_pixel_source_if.sv
// Pixel write handshake between the CPU side and the framebuffer.
// Master drives the request, slave answers with wr_ready.
`timescale 1ns/1ps
interface fb_pixel_source_if;
    logic        wr_valid;
    logic        wr_ready;
    logic [7:0]  wr_x;
    logic [7:0]  wr_y;
    logic [11:0] wr_data;

    modport master (
        output wr_valid, wr_x, wr_y, wr_data,
        input  wr_ready
    );

    modport slave (
        input  wr_valid, wr_x, wr_y, wr_data,
        output wr_ready
    );
endinterface

// File: rtl/fb_pixel_source.sv
// Up-scaled RGB444 framebuffer feeding the vga colour input.
// Two-cycle read pipeline, stalling write port and a full-buffer clear engine.
`timescale 1ns/1ps
module fb_pixel_source #(
    parameter int          WIDTH      = 800,
    parameter int          HEIGHT     = 600,
    parameter int          SCALE_LOG2 = 2,
    parameter logic [15:0] BORDER     = 16'h0000
) (
    input  logic        clk,
    input  logic        res,
    input  logic [15:0] pix_x,
    input  logic [15:0] pix_y,
    output logic [15:0] color,
    fb_pixel_source_if.slave wr,
    input  logic        clr,
    input  logic [11:0] clr_color,
    output logic        busy
);

    localparam int FB_W  = WIDTH >> SCALE_LOG2;
    localparam int FB_H  = HEIGHT >> SCALE_LOG2;
    localparam int DEPTH = FB_W * FB_H;
    localparam int AW    = $clog2(DEPTH);

    localparam logic [15:0]   W16  = 16'(WIDTH);
    localparam logic [15:0]   H16  = 16'(HEIGHT);
    localparam logic [AW-1:0] FBW  = AW'(FB_W);
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t        state, state_n;
    logic [AW-1:0] cnt, cnt_n;
    logic [11:0]   fill, fill_n;
    logic          ready_q;

    logic [11:0]   mem [DEPTH];
    logic [11:0]   ram_q;
    logic [AW-1:0] rd_addr;
    logic          vis0, vis1;
    logic          vis_c;
    logic [AW-1:0] ra_c;

    logic          we;
    logic [AW-1:0] wa;
    logic [11:0]   wd;
    logic          wr_fire;
    logic          wr_in;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        fill_n  = fill;
        unique case (state)
            IDLE: begin
                if (clr) begin
                    state_n = CLEAR;
                    cnt_n   = '0;
                    fill_n  = clr_color;
                end
            end
            CLEAR: begin
                cnt_n = cnt + AW'(1);
                if (cnt == LAST) begin
                    state_n = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (res) begin
            state   <= IDLE;
            cnt     <= '0;
            fill    <= '0;
            ready_q <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            fill    <= fill_n;
            ready_q <= (state_n == IDLE);
        end
    end

    assign busy        = (state == CLEAR);
    assign wr.wr_ready = ready_q;

    // Off-screen coordinates still handshake but never touch the RAM.
    assign wr_fire = wr.wr_valid && ready_q;
    assign wr_in   = (32'(wr.wr_x) < FB_W) && (32'(wr.wr_y) < FB_H);

    always_comb begin
        we = 1'b0;
        wa = '0;
        wd = '0;
        if (state == CLEAR) begin
            we = 1'b1;
            wa = cnt;
            wd = fill;
        end else if (wr_fire && wr_in) begin
            we = 1'b1;
            wa = AW'(wr.wr_y) * FBW + AW'(wr.wr_x);
            wd = wr.wr_data;
        end
    end

    // Compare before shifting so any coordinate beyond the screen is border.
    assign vis_c = (pix_x < W16) && (pix_y < H16);
    assign ra_c  = vis_c
                 ? AW'(pix_y >> SCALE_LOG2) * FBW + AW'(pix_x >> SCALE_LOG2)
                 : '0;

    always_ff @(posedge clk) begin
        if (res) begin
            vis0 <= 1'b0;
            vis1 <= 1'b0;
        end else begin
            vis0 <= vis_c;
            vis1 <= vis0;
        end
    end

    always_ff @(posedge clk) begin
        rd_addr <= ra_c;
    end

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wa] <= wd;
        end
        ram_q <= mem[rd_addr];
    end

    assign color = vis1 ? {4'h0, ram_q} : BORDER;

endmodule
